rt_config_loader: RTL and testbench

RT_CONFIG_LOADER -- requirements
Module: rt_config_loader

---
 rtl/rt_config_loader.sv | 135 +++++++++++++
 tb/tb_rt_config_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_config_loader.sv
// Streams host configuration words into a daisy-chained set of routing tables,
// then sends a check marker through the chain and waits for it to come back.
module rt_config_loader #(
    parameter int unsigned N_TABLES        = 8,
    parameter int unsigned WORDS_PER_TABLE = 512,
    parameter logic [15:0] MARKER          = 16'hA5C3,
    parameter int unsigned TIMEOUT         = 1024
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic                                              start,
    input  logic [15:0]                                       host_data,
    input  logic                                              host_valid,
    output logic                                              host_ready,
    output logic [15:0]                                       ram_config_out,
    output logic                                              ram_config_out_valid,
    input  logic [15:0]                                       ram_config_in,
    input  logic                                              ram_config_in_valid,
    output logic [((N_TABLES > 1) ? $clog2(N_TABLES) : 1)-1:0] table_index,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              error
);

    localparam int unsigned TI_W   = (N_TABLES > 1) ? $clog2(N_TABLES) : 1;
    localparam int unsigned TOTAL  = N_TABLES * WORDS_PER_TABLE;
    localparam int unsigned CNT_W  = $clog2(TOTAL) + 1;
    localparam int unsigned WPT_SH = $clog2(WORDS_PER_TABLE);
    localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned DATA_W = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MARK  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_n;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_n;
    logic [DATA_W-1:0] out_n;
    logic              out_valid_n;
    logic [CNT_W-1:0]  tbl_raw;
    logic [TI_W-1:0]   tbl_n;
    logic              xfer;

    assign xfer = host_valid & host_ready;

    // Next-state, counters and outgoing chain word
    always_comb begin
        state_n     = state;
        cnt_n       = word_cnt;
        timer_n     = timer;
        out_n       = ram_config_out;
        out_valid_n = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_n = S_LOAD;
                    cnt_n   = '0;
                    timer_n = '0;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    out_n       = host_data;
                    out_valid_n = 1'b1;
                    cnt_n       = word_cnt + CNT_W'(1);
                    if (cnt_n == CNT_W'(TOTAL)) begin
                        state_n = S_MARK;
                    end
                end
            end
            S_MARK: begin
                out_n       = MARKER;
                out_valid_n = 1'b1;
                timer_n     = '0;
                state_n     = S_WAIT;
            end
            S_WAIT: begin
                timer_n = timer + TMR_W'(1);
                // A returned word always decides the outcome, even on the timeout cycle
                if (ram_config_in_valid) begin
                    state_n = (ram_config_in == MARKER) ? S_DONE : S_ERROR;
                end else if (timer_n == TMR_W'(TIMEOUT)) begin
                    state_n = S_ERROR;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Table being loaded, saturating once every table has been filled
    always_comb begin
        tbl_raw = cnt_n >> WPT_SH;
        tbl_n   = TI_W'(tbl_raw);
        if (tbl_raw > CNT_W'(N_TABLES - 1)) begin
            tbl_n = TI_W'(N_TABLES - 1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                <= S_IDLE;
            word_cnt             <= '0;
            timer                <= '0;
            ram_config_out       <= '0;
            ram_config_out_valid <= 1'b0;
            table_index          <= '0;
            host_ready           <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            error                <= 1'b0;
        end else begin
            state                <= state_n;
            word_cnt             <= cnt_n;
            timer                <= timer_n;
            ram_config_out       <= out_n;
            ram_config_out_valid <= out_valid_n;
            table_index          <= tbl_n;
            host_ready           <= (state_n == S_LOAD);
            busy                 <= (state_n == S_LOAD) || (state_n == S_MARK) ||
                                    (state_n == S_WAIT);
            done                 <= (state_n == S_DONE);
            error                <= (state_n == S_ERROR);
        end
    end

endmodule

// File: tb/tb_rt_config_loader.sv
// Directed and randomized sessions for rt_config_loader against a word-level model.
module tb_rt_config_loader;

    localparam int unsigned NT    = 2;
    localparam int unsigned WPT   = 4;
    localparam int unsigned TMO   = 16;
    localparam int unsigned TOTAL = NT * WPT;
    localparam logic [15:0] MK    = 16'hA5C3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] host_data = '0;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [15:0] ram_config_out;
    logic        ram_config_out_valid;
    logic [15:0] ram_config_in = '0;
    logic        ram_config_in_valid = 1'b0;
    logic [0:0]  table_index;
    logic        busy;
    logic        done;
    logic        error;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] mdl_last = '0;

    rt_config_loader #(
        .N_TABLES       (NT),
        .WORDS_PER_TABLE(WPT),
        .MARKER         (MK),
        .TIMEOUT        (TMO)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .host_data           (host_data),
        .host_valid          (host_valid),
        .host_ready          (host_ready),
        .ram_config_out      (ram_config_out),
        .ram_config_out_valid(ram_config_out_valid),
        .ram_config_in       (ram_config_in),
        .ram_config_in_valid (ram_config_in_valid),
        .table_index         (table_index),
        .busy                (busy),
        .done                (done),
        .error               (error)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_tests++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    function automatic int exp_index(input int cnt);
        return (cnt / WPT > NT - 1) ? NT - 1 : cnt / WPT;
    endfunction

    // mode 0: back-to-back counting words, 1: every other cycle, 2: random gaps
    task automatic run_load(input int mode, input bit noise);
        int          cnt = 0;
        int          cyc = 0;
        bit          v;
        logic [15:0] d;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_clears_done", 32'(done), 32'd0);
        chk("start_clears_error", 32'(error), 32'd0);
        while (cnt < TOTAL && cyc < 200) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            d = (mode == 0) ? 16'(cnt + 1) : 16'($urandom);
            host_valid = v;
            host_data  = d;
            if (noise) begin
                start               = 1'($urandom);
                ram_config_in_valid = 1'($urandom);
                ram_config_in       = MK;
            end
            chk("load_ready", 32'(host_ready), 32'd1);
            chk("table_index", 32'(table_index), 32'(exp_index(cnt)));
            tick();
            chk("out_valid", 32'(ram_config_out_valid), 32'(v));
            if (v) begin
                mdl_last = d;
                cnt++;
            end
            chk("out_data", 32'(ram_config_out), 32'(mdl_last));
            cyc++;
        end
        start               = 1'b0;
        ram_config_in_valid = 1'b0;
        chk("load_budget", 32'(cnt), 32'(TOTAL));
        host_valid = 1'b1;
        host_data  = 16'hDEAD;
        chk("ready_after_last", 32'(host_ready), 32'd0);
        chk("table_index_sat", 32'(table_index), 32'(exp_index(TOTAL)));
        tick();
        host_valid = 1'b0;
        mdl_last   = MK;
        chk("marker_valid", 32'(ram_config_out_valid), 32'd1);
        chk("marker_data", 32'(ram_config_out), 32'(MK));
        chk("marker_busy", 32'(busy), 32'd1);
    endtask

    // Chain returns `word` after `delay` idle WAIT cycles (delay <= TMO-1)
    task automatic respond(input int delay, input logic [15:0] word, input bit noise);
        bit ok;
        for (int i = 0; i < delay; i++) begin
            if (noise) start = 1'($urandom);
            chk("wait_busy", 32'(busy), 32'd1);
            tick();
        end
        start               = 1'b0;
        ram_config_in_valid = 1'b1;
        ram_config_in       = word;
        tick();
        ram_config_in_valid = 1'b0;
        ok = (word == MK);
        chk("resp_done", 32'(done), 32'(ok));
        chk("resp_error", 32'(error), 32'(!ok));
        chk("resp_busy", 32'(busy), 32'd0);
        chk("resp_no_valid", 32'(ram_config_out_valid), 32'd0);
    endtask

    task automatic expect_timeout(input bit noise);
        int n = 0;
        while (!error && !done && n < 64) begin
            if (noise) start = 1'($urandom);
            tick();
            n++;
        end
        start = 1'b0;
        chk("timeout_cycles", 32'(n), 32'(TMO));
        chk("timeout_error", 32'(error), 32'd1);
        chk("timeout_no_done", 32'(done), 32'd0);
        chk("timeout_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] w;
        int          oc;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_ready", 32'(host_ready), 32'd0);
        chk("rst_out", 32'(ram_config_out), 32'd0);
        chk("rst_out_valid", 32'(ram_config_out_valid), 32'd0);
        chk("rst_index", 32'(table_index), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset = 1'b1;
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
        chk("idle_no_ready", 32'(host_ready), 32'd0);
        chk("idle_no_valid", 32'(ram_config_out_valid), 32'd0);

        // Full load, marker echoed
        run_load(0, 1'b0);
        respond(3, MK, 1'b0);

        // Returned words outside WAIT are ignored; done holds
        ram_config_in_valid = 1'b1;
        ram_config_in       = 16'h1234;
        repeat (3) tick();
        ram_config_in_valid = 1'b0;
        chk("done_held", 32'(done), 32'd1);
        chk("done_no_error", 32'(error), 32'd0);

        // Gappy host; marker arrives on the same cycle the timeout would fire
        run_load(1, 1'b0);
        respond(int'(TMO) - 1, MK, 1'b0);

        // Marker dropped
        run_load(2, 1'b0);
        expect_timeout(1'b0);

        // Wrong word, then restart from zero
        run_load(2, 1'b0);
        respond(0, 16'h1234, 1'b0);
        run_load(0, 1'b0);
        respond(5, MK, 1'b0);

        // Reset in the middle of a load
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            host_valid = 1'b1;
            host_data  = 16'(16'h0100 + i);
            tick();
        end
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_out", 32'(ram_config_out), 32'd0);
        chk("mid_rst_valid", 32'(ram_config_out_valid), 32'd0);
        chk("mid_rst_ready", 32'(host_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_index", 32'(table_index), 32'd0);
        mdl_last = '0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_ready", 32'(host_ready), 32'd0);
            chk("post_rst_valid", 32'(ram_config_out_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        host_valid = 1'b0;
        run_load(0, 1'b0);
        respond(2, MK, 1'b0);

        // start pulses during LOAD and WAIT change nothing
        run_load(2, 1'b1);
        expect_timeout(1'b1);
        run_load(2, 1'b1);
        respond(7, MK, 1'b1);

        // Random sessions
        for (int s = 0; s < 8; s++) begin
            run_load(int'($urandom_range(1, 2)), 1'($urandom));
            oc = int'($urandom_range(0, 2));
            if (oc == 0) begin
                respond(int'($urandom_range(0, TMO - 1)), MK, 1'($urandom));
            end else if (oc == 1) begin
                w = 16'($urandom);
                if (w == MK) w = w ^ 16'h0001;
                respond(int'($urandom_range(0, TMO - 1)), w, 1'($urandom));
            end else begin
                expect_timeout(1'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
